// File: rtl/trap_ctrl.sv
// trap_ctrl: ROB-side trap sequencer.
//
// When the committing ROB head carries an exception, this block reports it
// to the CSR unit, flushes the pipeline for FLUSH_CYCLES cycles, and then
// redirects fetch to the trap vector that the CSR unit returned. Commit is
// stalled (trap_busy) from the cycle after the trigger until the redirect is
// accepted. Every output is a register, so no input reaches an output
// combinationally.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rob_head_*               ROB head status: valid, error, ecause, pc[31:2], tval
//   trap_busy                trap in progress, ROB must hold the head
//   rob_flush                pipeline flush, REPORT through the end of FLUSH
//   rob_csr_valid/epc/ecause/tval
//                            one-cycle trap report to the CSR unit
//   csr_tvec                 trap vector[31:2] from the CSR unit
//   redirect_valid/pc/ready  fetch redirect handshake
//   trap_count               traps taken, wraps modulo 2^16
module trap_ctrl #(
  parameter int FLUSH_CYCLES = 2  // rob_flush high time, legal range 1..15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rob_head_valid,
  input  logic        rob_head_error,
  input  logic [4:0]  rob_head_ecause,
  input  logic [29:0] rob_head_pc,
  input  logic [31:0] rob_head_tval,
  output logic        trap_busy,
  output logic        rob_flush,
  output logic        rob_csr_valid,
  output logic [29:0] rob_csr_epc,
  output logic [4:0]  rob_csr_ecause,
  output logic [31:0] rob_csr_tval,
  input  logic [29:0] csr_tvec,
  output logic        redirect_valid,
  output logic [29:0] redirect_pc,
  input  logic        redirect_ready,
  output logic [15:0] trap_count
);

  typedef enum logic [1:0] {IDLE, REPORT, FLUSH, REDIRECT} state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t     state;
  logic [3:0] flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      flush_cnt      <= '0;
      trap_busy      <= 1'b0;
      rob_flush      <= 1'b0;
      rob_csr_valid  <= 1'b0;
      rob_csr_epc    <= '0;
      rob_csr_ecause <= '0;
      rob_csr_tval   <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      trap_count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Head inputs only matter here, so anything presented while busy
          // is naturally ignored.
          if (rob_head_valid && rob_head_error) begin
            rob_csr_epc    <= rob_head_pc;
            rob_csr_ecause <= rob_head_ecause;
            rob_csr_tval   <= rob_head_tval;
            rob_csr_valid  <= 1'b1;
            rob_flush      <= 1'b1;
            trap_busy      <= 1'b1;
            state          <= REPORT;
          end
        end
        REPORT: begin
          // tvec is taken at the end of the report cycle; any CSR update the
          // report causes lands afterwards and is not seen here.
          redirect_pc   <= csr_tvec;
          rob_csr_valid <= 1'b0;
          flush_cnt     <= FLUSH_LOAD;
          if (FLUSH_CYCLES > 1) begin
            state <= FLUSH;
          end else begin
            rob_flush      <= 1'b0;
            redirect_valid <= 1'b1;
            state          <= REDIRECT;
          end
        end
        FLUSH: begin
          // REPORT already counted as the first flush cycle, so the counter
          // covers the remaining FLUSH_CYCLES-1.
          if (flush_cnt == 4'd1) begin
            rob_flush      <= 1'b0;
            redirect_valid <= 1'b1;
            state          <= REDIRECT;
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
          end
        end
        REDIRECT: begin
          if (redirect_ready) begin
            redirect_valid <= 1'b0;
            trap_busy      <= 1'b0;
            trap_count     <= trap_count + 16'd1;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: a vector table for the basic trap flow plus
// hand sequences for backpressure, head changes while busy, flush length for
// several FLUSH_CYCLES builds, reset mid-trap and trap_count wrap.
module tb_trap_ctrl;
  logic        clk = 1'b0;
  logic        rst, hv, he, rdy;
  logic [4:0]  ec;
  logic [29:0] pc, tvec;
  logic [31:0] tval;

  logic        busy, flush, cv, rv;
  logic [29:0] epc, rpc;
  logic [4:0]  oec;
  logic [31:0] otval;
  logic [15:0] cnt;

  logic        busy1, flush1, cv1, rv1, busy4, flush4, cv4, rv4;
  logic [29:0] epc1, rpc1, epc4, rpc4;
  logic [4:0]  oec1, oec4;
  logic [31:0] otval1, otval4;
  logic [15:0] cnt1, cnt4;

  always #5 clk = ~clk;

  trap_ctrl #(.FLUSH_CYCLES(2)) d2 (
    .clk(clk), .rst(rst), .rob_head_valid(hv), .rob_head_error(he),
    .rob_head_ecause(ec), .rob_head_pc(pc), .rob_head_tval(tval),
    .trap_busy(busy), .rob_flush(flush), .rob_csr_valid(cv),
    .rob_csr_epc(epc), .rob_csr_ecause(oec), .rob_csr_tval(otval),
    .csr_tvec(tvec), .redirect_valid(rv), .redirect_pc(rpc),
    .redirect_ready(rdy), .trap_count(cnt));

  trap_ctrl #(.FLUSH_CYCLES(1)) d1 (
    .clk(clk), .rst(rst), .rob_head_valid(hv), .rob_head_error(he),
    .rob_head_ecause(ec), .rob_head_pc(pc), .rob_head_tval(tval),
    .trap_busy(busy1), .rob_flush(flush1), .rob_csr_valid(cv1),
    .rob_csr_epc(epc1), .rob_csr_ecause(oec1), .rob_csr_tval(otval1),
    .csr_tvec(tvec), .redirect_valid(rv1), .redirect_pc(rpc1),
    .redirect_ready(rdy), .trap_count(cnt1));

  trap_ctrl #(.FLUSH_CYCLES(4)) d4 (
    .clk(clk), .rst(rst), .rob_head_valid(hv), .rob_head_error(he),
    .rob_head_ecause(ec), .rob_head_pc(pc), .rob_head_tval(tval),
    .trap_busy(busy4), .rob_flush(flush4), .rob_csr_valid(cv4),
    .rob_csr_epc(epc4), .rob_csr_ecause(oec4), .rob_csr_tval(otval4),
    .csr_tvec(tvec), .redirect_valid(rv4), .redirect_pc(rpc4),
    .redirect_ready(rdy), .trap_count(cnt4));

  // flags = {trap_busy, rob_flush, rob_csr_valid, redirect_valid}
  typedef struct {
    logic        rst, hv, he, rdy;
    logic [4:0]  ec;
    logic [29:0] pc, tvec;
    logic [31:0] tval;
    logic [3:0]  x_flags;
    logic [4:0]  x_ec;
    logic [29:0] x_epc, x_rpc;
    logic [31:0] x_tval;
    logic [15:0] x_cnt;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] f, input logic [4:0] e,
                         input logic [29:0] p, input logic [31:0] t,
                         input logic [29:0] r, input logic [15:0] c);
    chk({tag, " flags"}, {60'd0, busy, flush, cv, rv}, {60'd0, f});
    chk({tag, " csr"}, {e, p, 29'd0}, {oec, epc, 29'd0});
    chk({tag, " tval"}, {32'd0, otval}, {32'd0, t});
    chk({tag, " rpc"}, {34'd0, rpc}, {34'd0, r});
    chk({tag, " cnt"}, {48'd0, cnt}, {48'd0, c});
  endtask

  function automatic vec_t mk(input logic r, input logic v, input logic e, input logic [4:0] c,
                              input logic [29:0] p, input logic [31:0] t, input logic [29:0] tv,
                              input logic rd, input logic [3:0] xf, input logic [4:0] xe,
                              input logic [29:0] xp, input logic [31:0] xt,
                              input logic [29:0] xr, input logic [15:0] xc);
    vec_t s;
    s.rst = r; s.hv = v; s.he = e; s.ec = c; s.pc = p; s.tval = t; s.tvec = tv; s.rdy = rd;
    s.x_flags = xf; s.x_ec = xe; s.x_epc = xp; s.x_tval = xt; s.x_rpc = xr; s.x_cnt = xc;
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic head(input logic v, input logic e, input logic [4:0] c,
                      input logic [29:0] p, input logic [31:0] t);
    hv = v; he = e; ec = c; pc = p; tval = t;
  endtask

  vec_t tbl[11];
  int   fl1, fl2, fl4, rep1, rep2, rep4, red1, red2, red4;
  logic [15:0] pre_cnt;

  initial begin
    rst = 1'b1; rdy = 1'b1; tvec = '0;
    head(0, 0, 0, 0, 0);

    // Rows: inputs presented before an edge, expected outputs just after it.
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 1, 4'b0000, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 1, 2, 30'h40, 32'hDEADBEEF, 30'h20000000, 1,
                 4'b1110, 2, 30'h40, 32'hDEADBEEF, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 30'h20000000, 1,
                 4'b1100, 2, 30'h40, 32'hDEADBEEF, 30'h20000000, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 30'h20000000, 1,
                 4'b1001, 2, 30'h40, 32'hDEADBEEF, 30'h20000000, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 30'h20000000, 1,
                 4'b0000, 2, 30'h40, 32'hDEADBEEF, 30'h20000000, 1);
    // error without valid, then valid without error: both ignored
    tbl[5]  = mk(0, 0, 1, 7, 30'h99, 32'h77, 30'h0, 1,
                 4'b0000, 2, 30'h40, 32'hDEADBEEF, 30'h20000000, 1);
    tbl[6]  = mk(0, 1, 0, 7, 30'h99, 32'h77, 30'h0, 1,
                 4'b0000, 2, 30'h40, 32'hDEADBEEF, 30'h20000000, 1);
    // tvec sampled during REPORT only: 0x123 in IDLE, 0x400 in REPORT, 0x800 after
    tbl[7]  = mk(0, 1, 1, 3, 30'h10, 32'h55, 30'h123, 1,
                 4'b1110, 3, 30'h10, 32'h55, 30'h20000000, 1);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 30'h400, 1,
                 4'b1100, 3, 30'h10, 32'h55, 30'h400, 1);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 30'h800, 1,
                 4'b1001, 3, 30'h10, 32'h55, 30'h400, 1);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 30'h800, 1,
                 4'b0000, 3, 30'h10, 32'h55, 30'h400, 2);

    #2;
    for (int i = 0; i < 11; i++) begin
      rst = tbl[i].rst; rdy = tbl[i].rdy; tvec = tbl[i].tvec;
      head(tbl[i].hv, tbl[i].he, tbl[i].ec, tbl[i].pc, tbl[i].tval);
      tick();
      chk_all($sformatf("vec%0d", i), tbl[i].x_flags, tbl[i].x_ec, tbl[i].x_epc,
              tbl[i].x_tval, tbl[i].x_rpc, tbl[i].x_cnt);
    end

    // Backpressure: redirect held 6 cycles while ready is low for 5.
    rdy = 1'b0; tvec = 30'h3000;
    head(1, 1, 1, 30'h200, 32'h1);
    tick();
    head(0, 0, 0, 0, 0);
    tick();
    tick();
    chk("bp enter", {62'd0, rv, busy}, 64'd3);
    for (int i = 0; i < 5; i++) begin
      tvec = 30'h3FF0 + 30'(i);
      tick();
      chk($sformatf("bp hold%0d", i), {rv, busy, rpc, cnt}, {1'b1, 1'b1, 30'h3000, 16'd2});
    end
    rdy = 1'b1;
    tick();
    chk("bp accept", {rv, busy, rpc, cnt}, {1'b0, 1'b0, 30'h3000, 16'd3});

    // Second error raised while busy is ignored, then taken right after.
    head(1, 1, 4, 30'h300, 32'h4);
    tick();
    chk("hd report1", {cv, oec}, {1'b1, 5'd4});
    head(1, 1, 5, 30'h304, 32'h5);
    tick();
    chk("hd flush", {cv, oec, epc}, {1'b0, 5'd4, 30'h300});
    tick();
    chk("hd redirect", {rv, oec, epc}, {1'b1, 5'd4, 30'h300});
    tick();
    chk("hd idle", {busy, cnt}, {1'b0, 16'd4});
    tick();
    head(0, 0, 0, 0, 0);
    chk("hd report2", {busy, cv, oec, epc, otval}, {1'b1, 1'b1, 5'd5, 30'h304, 32'h5});
    tick();
    tick();
    tick();
    chk("hd done", {busy, rv, cnt}, {1'b0, 1'b0, 16'd5});

    // Flush length and REPORT-to-REDIRECT spacing for each build.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    fl1 = 0; fl2 = 0; fl4 = 0;
    rep1 = -1; rep2 = -1; rep4 = -1; red1 = -1; red2 = -1; red4 = -1;
    head(1, 1, 9, 30'h500, 32'h9);
    for (int c = 0; c < 20; c++) begin
      tick();
      head(0, 0, 0, 0, 0);
      fl1 += int'(flush1); fl2 += int'(flush); fl4 += int'(flush4);
      if (cv1 && rep1 < 0) rep1 = c;
      if (cv  && rep2 < 0) rep2 = c;
      if (cv4 && rep4 < 0) rep4 = c;
      if (rv1 && red1 < 0) red1 = c;
      if (rv  && red2 < 0) red2 = c;
      if (rv4 && red4 < 0) red4 = c;
    end
    chk("f1 flush", 64'(fl1), 64'd1);
    chk("f2 flush", 64'(fl2), 64'd2);
    chk("f4 flush", 64'(fl4), 64'd4);
    chk("f1 report", 64'(rep1), 64'd0);
    chk("f1 space", 64'(red1 - rep1), 64'd1);
    chk("f2 space", 64'(red2 - rep2), 64'd2);
    chk("f4 space", 64'(red4 - rep4), 64'd4);
    chk("f cnt", {cnt1, cnt, cnt4}, {16'd1, 16'd1, 16'd1});

    // Reset mid-FLUSH.
    head(1, 1, 6, 30'h600, 32'h6);
    tick();
    head(0, 0, 0, 0, 0);
    tick();
    pre_cnt = cnt;
    chk("rf pre", {flush, cv, pre_cnt}, {1'b1, 1'b0, 16'd1});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all("rst flush", 4'b0000, 0, 0, 0, 0, 0);

    // Reset mid-REDIRECT: the pending redirect is dropped, no count.
    rdy = 1'b0;
    head(1, 1, 6, 30'h600, 32'h6);
    tick();
    head(0, 0, 0, 0, 0);
    tick();
    tick();
    chk("rr pre", {62'd0, rv, busy}, 64'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0; rdy = 1'b1;
    chk_all("rst redir", 4'b0000, 0, 0, 0, 0, 0);
    tick();
    chk("rr after", {busy, rv, cnt}, {1'b0, 1'b0, 16'd0});

    // Wrap: preload 0xFFFF, one more trap brings it to 0.
    force d2.trap_count = 16'hFFFF;
    #1;
    release d2.trap_count;
    head(1, 1, 1, 30'h700, 32'h7);
    tick();
    head(0, 0, 0, 0, 0);
    tick();
    tick();
    chk("wrap pre", {rv, cnt}, {1'b1, 16'hFFFF});
    tick();
    chk("wrap", {busy, cnt}, {1'b0, 16'h0000});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard bound on simulated time.
  initial begin
    #20000;
    $display("FAIL timeout: got no end expected end by 20000");
    $fatal(1);
  end
endmodule
